// File: rtl/line_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | line_streamer: drains ping-pong banks of the line RAM into a pixel stream. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module line_streamer #(
  parameter int ADDR_SIZE = 6,
  parameter int DATA_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 bank_full_i,
  input  logic                 bank_sel_i,
  output logic                 bank_free_o,
  output logic                 bank_free_idx_o,
  output logic                 overflow_o,
  output logic [ADDR_SIZE-1:0] addr_B,
  input  logic [DATA_SIZE-1:0] data_out_B,
  output logic [DATA_SIZE-1:0] px_data_o,
  output logic                 px_valid_o,
  input  logic                 px_ready_i,
  output logic                 px_last_o
);

  localparam int                 c_IDX_W    = ADDR_SIZE - 1;
  localparam logic [c_IDX_W-1:0] c_IDX_MAX  = {c_IDX_W{1'b1}};
  localparam logic [1:0]         c_FIFO_TOP = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t               r_state;
  logic [1:0]           r_full;
  logic                 r_cur;
  logic [c_IDX_W-1:0]   r_idx;
  logic                 r_rd_pend;
  logic                 r_rd_last;
  logic [DATA_SIZE:0]   r_fifo [3];
  logic [1:0]           r_wp;
  logic [1:0]           r_rp;
  logic [1:0]           r_count;
  logic                 r_out_bank;

  logic                 w_pop;
  logic                 w_last_pop;
  logic                 w_credit;
  logic                 w_drain_hit;
  logic                 w_start;
  logic                 w_issue;
  logic [1:0]           w_set;
  logic [1:0]           w_clr;

  // The read address is the next word to fetch, so it only moves when a read issues.
  assign addr_B                  = {r_cur, r_idx};
  assign px_valid_o              = (r_count != 2'd0);
  assign {px_last_o, px_data_o}  = r_fifo[r_rp];

  assign w_pop       = px_valid_o & px_ready_i;
  assign w_last_pop  = w_pop & px_last_o;
  assign w_credit    = ({1'b0, r_count} + {2'b00, r_rd_pend}) < 3'd3;
  assign w_drain_hit = (r_out_bank == r_cur) && (px_valid_o || r_rd_pend);
  assign w_start     = (r_state != ST_FETCH) && r_full[r_cur] && !w_drain_hit;
  assign w_issue     = w_credit && ((r_state == ST_FETCH) || w_start);
  assign w_set       = {bank_full_i & bank_sel_i, bank_full_i & ~bank_sel_i};
  assign w_clr       = {w_last_pop & r_out_bank, w_last_pop & ~r_out_bank};

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state         <= ST_IDLE;
      r_full          <= 2'b00;
      r_cur           <= 1'b0;
      r_idx           <= '0;
      r_rd_pend       <= 1'b0;
      r_rd_last       <= 1'b0;
      r_wp            <= 2'd0;
      r_rp            <= 2'd0;
      r_count         <= 2'd0;
      r_out_bank      <= 1'b0;
      bank_free_o     <= 1'b0;
      bank_free_idx_o <= 1'b0;
      overflow_o      <= 1'b0;
      for (int i = 0; i < 3; i++) r_fifo[i] <= '0;
    end else begin
      // A new fill of the same bank overrides the release of its previous contents.
      r_full <= (r_full & ~w_clr) | w_set;
      if (bank_full_i && r_full[bank_sel_i]) overflow_o <= 1'b1;

      bank_free_o <= w_last_pop;
      if (w_last_pop) begin
        bank_free_idx_o <= r_out_bank;
        r_out_bank      <= ~r_out_bank;
      end

      r_rd_pend <= w_issue;
      if (w_issue) r_rd_last <= (r_idx == c_IDX_MAX);

      if (r_rd_pend) begin
        r_fifo[r_wp] <= {r_rd_last, data_out_B};
        r_wp         <= (r_wp == c_FIFO_TOP) ? 2'd0 : r_wp + 2'd1;
      end
      if (w_pop) r_rp <= (r_rp == c_FIFO_TOP) ? 2'd0 : r_rp + 2'd1;
      r_count <= r_count + {1'b0, r_rd_pend} - {1'b0, w_pop};

      if (w_issue) begin
        if (r_idx == c_IDX_MAX) begin
          r_idx   <= '0;
          r_cur   <= ~r_cur;
          r_state <= ST_WAIT;
        end else begin
          r_idx   <= r_idx + 1'b1;
          r_state <= ST_FETCH;
        end
      end else if (r_state != ST_FETCH) begin
        r_state <= w_start ? ST_FETCH : ST_IDLE;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_line_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_line_streamer: scoreboard bench with a bank-level reference model.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_line_streamer;

  localparam int AW  = 6;
  localparam int DW  = 32;
  localparam int WPB = 32;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          bank_full_i = 1'b0;
  logic          bank_sel_i = 1'b0;
  logic          px_ready_i = 1'b0;
  logic          bank_free_o, bank_free_idx_o, overflow_o;
  logic [AW-1:0] addr_B;
  logic [DW-1:0] data_out_B;
  logic [DW-1:0] px_data_o;
  logic          px_valid_o, px_last_o;

  line_streamer #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) dut (
    .clk(clk), .nrst(nrst),
    .bank_full_i(bank_full_i), .bank_sel_i(bank_sel_i),
    .bank_free_o(bank_free_o), .bank_free_idx_o(bank_free_idx_o),
    .overflow_o(overflow_o), .addr_B(addr_B), .data_out_B(data_out_B),
    .px_data_o(px_data_o), .px_valid_o(px_valid_o),
    .px_ready_i(px_ready_i), .px_last_o(px_last_o)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram [2*WPB];
  always @(posedge clk) data_out_B <= ram[addr_B];

  int checks = 0;
  int errors = 0;

  typedef struct packed { logic l; logic [DW-1:0] d; } exp_t;
  exp_t exp_q[$];
  int   free_q[$];
  bit   m_flag[2];
  bit   m_queued[2];
  int   m_cur;
  bit   m_ovf;

  bit   mon_en = 1'b0;
  int   ready_mode = 0;
  int   pops = 0;
  bit   valid_seen = 1'b0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endfunction

  // Reference model: filled banks are streamed whole, strictly alternating from bank 0.
  function automatic void model_advance();
    while (m_flag[m_cur] && !m_queued[m_cur]) begin
      for (int i = 0; i < WPB; i++) exp_q.push_back({(i == WPB-1), ram[m_cur*WPB + i]});
      free_q.push_back(m_cur);
      m_queued[m_cur] = 1'b1;
      m_cur = 1 - m_cur;
    end
  endfunction

  function automatic void model_full(input int b);
    if (m_flag[b]) m_ovf = 1'b1;
    else m_flag[b] = 1'b1;
    model_advance();
  endfunction

  function automatic void model_free(input int b);
    m_flag[b] = 1'b0;
    m_queued[b] = 1'b0;
    model_advance();
  endfunction

  function automatic void model_clear();
    m_flag = '{0, 0}; m_queued = '{0, 0}; m_cur = 0; m_ovf = 1'b0;
    exp_q.delete(); free_q.delete();
  endfunction

  // Monitor: pops the scoreboard on every handshake and checks stalls and releases.
  logic          prev_v, prev_r, prev_l;
  logic [DW-1:0] prev_d;
  bit            pend_free;
  int            pend_idx;
  exp_t          e;

  always @(negedge clk) begin
    if (!mon_en) begin
      prev_v = 1'b0;
      pend_free = 1'b0;
    end else begin
      if (px_valid_o) valid_seen = 1'b1;
      if (prev_v && !prev_r)
        check("stall_hold", {30'd0, px_valid_o, px_last_o, px_data_o}, {30'd0, 1'b1, prev_l, prev_d});
      if (pend_free) begin
        check("bank_free", {62'd0, bank_free_o, bank_free_idx_o}, {62'd0, 1'b1, pend_idx[0]});
        model_free(pend_idx);
        pend_free = 1'b0;
      end else if (bank_free_o) begin
        checks++; errors++;
        $display("FAIL bank_free_spurious actual=1 required=0 at %0t", $time);
      end
      if (px_valid_o && px_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL px_word_unexpected actual=%0h required=none at %0t", px_data_o, $time);
        end else begin
          e = exp_q.pop_front();
          check("px_word", {31'd0, px_last_o, px_data_o}, {31'd0, e.l, e.d});
          pops++;
          if (e.l) begin
            pend_free = 1'b1;
            pend_idx  = free_q.pop_front();
          end
        end
      end
      prev_v = px_valid_o; prev_r = px_ready_i; prev_l = px_last_o; prev_d = px_data_o;
    end
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1:       px_ready_i = 1'b1;
      2:       px_ready_i = 1'($urandom_range(0, 1));
      default: px_ready_i = 1'b0;
    endcase
  end

  task automatic check_reset_outputs();
    check("rst_valid", {63'd0, px_valid_o}, 64'd0);
    check("rst_data", {32'd0, px_data_o}, 64'd0);
    check("rst_last", {63'd0, px_last_o}, 64'd0);
    check("rst_free", {63'd0, bank_free_o}, 64'd0);
    check("rst_free_idx", {63'd0, bank_free_idx_o}, 64'd0);
    check("rst_overflow", {63'd0, overflow_o}, 64'd0);
    check("rst_addr", {58'd0, addr_B}, 64'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    mon_en = 1'b0; nrst = 1'b0; bank_full_i = 1'b0; ready_mode = 0;
    model_clear();
    #1 check_reset_outputs();
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1; mon_en = 1'b1; valid_seen = 1'b0; pops = 0;
  endtask

  task automatic fill_bank(input int b, input bit rnd);
    for (int i = 0; i < WPB; i++) ram[b*WPB + i] = rnd ? DW'($urandom) : DW'(i);
  endtask

  task automatic pulse(input int b);
    @(posedge clk); #1;
    bank_full_i = 1'b1; bank_sel_i = 1'(b);
    model_full(b);
    @(posedge clk); #1;
    bank_full_i = 1'b0;
  endtask

  task automatic wait_drained(input string name, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !m_flag[0] && !m_flag[1] && !pend_free) begin
        done = 1'b1;
        break;
      end
    end
    check(name, {63'd0, done}, 64'd1);
  endtask

  task automatic wait_freed(input int b, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!m_flag[b]) begin done = 1'b1; break; end
    end
    check("wait_freed", {63'd0, done}, 64'd1);
  endtask

  int gaps;

  initial begin
    model_clear();
    fill_bank(0, 1'b0);
    fill_bank(1, 1'b1);
    repeat (2) @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1 nrst = 1'b1; mon_en = 1'b1;

    // Single bank of words 0..31 with first-word latency.
    ready_mode = 1;
    @(posedge clk); #1;
    bank_full_i = 1'b1; bank_sel_i = 1'b0; model_full(0);
    @(posedge clk); #1 bank_full_i = 1'b0;
    @(negedge clk);
    @(negedge clk); check("latency_early", {63'd0, px_valid_o}, 64'd0);
    @(negedge clk); check("latency_first", {63'd0, px_valid_o}, 64'd1);
    wait_drained("drain_single", 100);

    // Both banks back to back at full rate.
    do_reset();
    fill_bank(0, 1'b1); fill_bank(1, 1'b1);
    ready_mode = 1;
    pulse(0); pulse(1);
    for (int i = 0; i < 20 && !px_valid_o; i++) @(negedge clk);
    gaps = 0;
    repeat (60) begin
      @(negedge clk);
      if (!px_valid_o) gaps++;
    end
    check("no_gap", 64'(gaps), 64'd0);
    wait_drained("drain_pair", 200);

    // Random backpressure with banks refilled as soon as released.
    do_reset();
    fill_bank(0, 1'b1); fill_bank(1, 1'b1);
    ready_mode = 2;
    pulse(0); pulse(1);
    wait_freed(0, 400);
    fill_bank(0, 1'b1); pulse(0);
    wait_freed(1, 400);
    fill_bank(1, 1'b1); pulse(1);
    wait_drained("drain_random", 800);

    // Overflow on a refill of a still-full bank, sticky until reset.
    do_reset();
    fill_bank(0, 1'b1);
    ready_mode = 0;
    pulse(0);
    repeat (3) @(posedge clk);
    pulse(0);
    @(negedge clk); check("ovf_set", {63'd0, overflow_o}, {63'd0, m_ovf});
    ready_mode = 1;
    wait_drained("drain_ovf", 200);
    check("ovf_sticky", {63'd0, overflow_o}, 64'd1);

    // Asynchronous reset in the middle of a bank, then a clean restart.
    do_reset();
    fill_bank(0, 1'b1);
    ready_mode = 1;
    pulse(0);
    for (int i = 0; i < 100 && pops < 10; i++) @(negedge clk);
    check("mid_progress", {63'd0, (pops >= 10)}, 64'd1);
    do_reset();
    fill_bank(0, 1'b1);
    ready_mode = 1;
    pulse(0);
    wait_drained("drain_restart", 200);

    // Bank 1 alone must wait until bank 0 has been filled and streamed.
    do_reset();
    fill_bank(0, 1'b1); fill_bank(1, 1'b1);
    ready_mode = 1;
    pulse(1);
    repeat (20) @(negedge clk);
    check("bank1_waits", {63'd0, valid_seen}, 64'd0);
    pulse(0);
    wait_drained("drain_order", 300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
